// File: rtl/team_06_i2s_rx_if.sv
// Sample handshake bundle between the I2S receiver and its downstream consumer.
interface team_06_i2s_rx_if #(
    parameter int unsigned SAMPLE_W = 8
) ();
    logic [SAMPLE_W-1:0] sample_data;
    logic                sample_ch;
    logic                sample_valid;
    logic                sample_ready;
    logic                overrun;

    modport master (
        output sample_data,
        output sample_ch,
        output sample_valid,
        output overrun,
        input  sample_ready
    );

    modport slave (
        input  sample_data,
        input  sample_ch,
        input  sample_valid,
        input  overrun,
        output sample_ready
    );
endinterface

// File: rtl/team_06_i2s_rx.sv
// I2S master receiver: generates i2sclk/wsADC and deserialises ADC data into samples.
// Define I2S_RX_BOTH_CH_EN to capture right half-frames as well as left ones.
module team_06_i2s_rx #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned FRAME_BITS  = 32,
    parameter int unsigned SAMPLE_W    = 8,
    parameter int unsigned DATA_OFFSET = 1
) (
    input  logic hwclk,
    input  logic reset,
    input  logic enable,
    input  logic adc_serial_in,
    output logic i2sclk,
    output logic wsADC,
    team_06_i2s_rx_if.master smp
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = (FRAME_BITS > 2) ? $clog2(FRAME_BITS) : 1;

    localparam logic [DIV_W-1:0] RISE_AT    = DIV_W'(CLK_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] FALL_AT    = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] FIRST_DATA = BIT_W'(DATA_OFFSET);
    localparam logic [BIT_W-1:0] LAST_DATA  = BIT_W'(DATA_OFFSET + SAMPLE_W - 1);

    typedef enum logic {StIdle, StRun} state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_q;
    logic [BIT_W-1:0]    bit_q;
    logic [SAMPLE_W-1:0] shift_q;
    logic                pend_q;

    logic rise;
    logic fall;
    logic in_window;
    logic ch_ok;

    assign rise      = (state_q == StRun) && (div_q == RISE_AT);
    assign fall      = (state_q == StRun) && (div_q == FALL_AT);
    assign in_window = (bit_q >= FIRST_DATA) && (bit_q <= LAST_DATA);

`ifdef I2S_RX_BOTH_CH_EN
    assign ch_ok = 1'b1;
`else
    assign ch_ok = ~wsADC;
`endif

    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q          <= StIdle;
            div_q            <= '0;
            bit_q            <= '0;
            shift_q          <= '0;
            pend_q           <= 1'b0;
            i2sclk           <= 1'b0;
            wsADC            <= 1'b0;
            smp.sample_data  <= '0;
            smp.sample_ch    <= 1'b0;
            smp.sample_valid <= 1'b0;
            smp.overrun      <= 1'b0;
        end else begin
            // Output stage: a completion always wins over an accept in the same cycle.
            smp.overrun <= 1'b0;
            pend_q      <= 1'b0;
            if (pend_q) begin
                smp.sample_data  <= shift_q;
`ifdef I2S_RX_BOTH_CH_EN
                smp.sample_ch    <= wsADC;
`else
                smp.sample_ch    <= 1'b0;
`endif
                smp.sample_valid <= 1'b1;
                smp.overrun      <= smp.sample_valid && !smp.sample_ready;
            end else if (smp.sample_valid && smp.sample_ready) begin
                smp.sample_valid <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    i2sclk  <= 1'b0;
                    wsADC   <= 1'b0;
                    div_q   <= '0;
                    bit_q   <= '0;
                    shift_q <= '0;
                    if (enable) state_q <= StRun;
                end
                StRun: begin
                    if (!enable) begin
                        state_q <= StIdle;
                        i2sclk  <= 1'b0;
                        wsADC   <= 1'b0;
                        div_q   <= '0;
                        bit_q   <= '0;
                        shift_q <= '0;
                    end else begin
                        div_q <= (div_q == FALL_AT) ? '0 : div_q + DIV_W'(1);
                        if (rise) begin
                            i2sclk <= 1'b1;
                            if (in_window) shift_q <= {shift_q[SAMPLE_W-2:0], adc_serial_in};
                            if ((bit_q == LAST_DATA) && ch_ok) pend_q <= 1'b1;
                        end
                        if (fall) begin
                            i2sclk <= 1'b0;
                            if (bit_q == LAST_BIT) begin
                                bit_q <= '0;
                                wsADC <= ~wsADC;
                            end else begin
                                bit_q <= bit_q + BIT_W'(1);
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
